card_dealer: RTL and testbench

- Owns the 52-card deck: fills it in order, shuffles it in place (Fisher-Yates with rejection sampling, 16-bit LFSR), then hands out one card per request to the blackjack state machine.
- Sits directly upstream of the blackjack state machine and replaces the free-running shuffle array with a request/valid card stream.
- Card value is the rank 1..13 (4 bits), matching the state machine's card input; suit is provided for display.

---
 rtl/card_dealer_if.sv | 22 ++
 rtl/card_dealer.sv | 128 ++++++++++++
 tb/tb_card_dealer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Request/valid card stream between the deck dealer (slave) and the
// blackjack state machine that consumes cards (master).
interface card_dealer_if;
    logic       shuffle_start;
    logic       deal_req;
    logic       card_valid;
    logic [3:0] card_value;
    logic [1:0] card_suit;
    logic       deck_ready;
    logic [5:0] cards_left;
    logic       deal_err;

    modport master (
        output shuffle_start, deal_req,
        input  card_valid, card_value, card_suit, deck_ready, cards_left, deal_err
    );

    modport slave (
        input  shuffle_start, deal_req,
        output card_valid, card_value, card_suit, deck_ready, cards_left, deal_err
    );
endinterface

// File: rtl/card_dealer.sv
// Owns the deck: fills it in order, Fisher-Yates shuffles it in place using a
// 16-bit LFSR with rejection sampling, then deals one card per request.
module card_dealer #(
    parameter int unsigned DECK_SIZE = 52,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic          clock,
    input logic          reset,
    card_dealer_if.slave bus
);
    typedef enum logic [1:0] {StFill, StShuffle, StReady} state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  deck_q [DECK_SIZE];
    logic [5:0]  deck_d [DECK_SIZE];
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  left_q, left_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [3:0]  value_q, value_d;
    logic [1:0]  suit_q, suit_d;
    logic [5:0]  pick;
    logic [5:0]  dealt;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        deck_d  = deck_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        left_d  = left_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        value_d = value_q;
        suit_d  = suit_q;
        // Candidate swap partner comes from the pre-shift LFSR value.
        pick    = lfsr_q[5:0];
        dealt   = deck_q[ptr_q];

        if (bus.shuffle_start) begin
            state_d = StFill;
            ready_d = 1'b0;
            left_d  = '0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                StFill: begin
                    for (int k = 0; k < int'(DECK_SIZE); k++) begin
                        deck_d[k] = 6'(k);
                    end
                    idx_d   = 6'(DECK_SIZE - 1);
                    ptr_d   = '0;
                    left_d  = '0;
                    ready_d = 1'b0;
                    state_d = StShuffle;
                end
                StShuffle: begin
                    // Out-of-range picks are rejected and retried next cycle.
                    if (pick <= idx_q) begin
                        deck_d[idx_q] = deck_q[pick];
                        deck_d[pick]  = deck_q[idx_q];
                        idx_d         = idx_q - 6'd1;
                        if (idx_q == 6'd1) begin
                            state_d = StReady;
                            left_d  = 6'(DECK_SIZE);
                            ready_d = 1'b1;
                        end
                    end
                end
                StReady: begin
                    if (bus.deal_req) begin
                        if (left_q != '0) begin
                            valid_d = 1'b1;
                            value_d = 4'(dealt % 6'd13) + 4'd1;
                            suit_d  = 2'(dealt / 6'd13);
                            ptr_d   = ptr_q + 6'd1;
                            left_d  = left_q - 6'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
            lfsr_q  <= LFSR_SEED;
            for (int k = 0; k < int'(DECK_SIZE); k++) begin
                deck_q[k] <= 6'(k);
            end
            idx_q   <= 6'(DECK_SIZE - 1);
            ptr_q   <= '0;
            left_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            value_q <= '0;
            suit_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            deck_q  <= deck_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            value_q <= value_d;
            suit_q  <= suit_d;
        end
    end

    assign bus.card_valid = valid_q;
    assign bus.card_value = value_q;
    assign bus.card_suit  = suit_q;
    assign bus.deck_ready = ready_q;
    assign bus.cards_left = left_q;
    assign bus.deal_err   = err_q;
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: shuffle timing and order against a software
// Fisher-Yates model, full deal-out, empty-deck error, reshuffle and async reset.
module tb_card_dealer;
    logic clock = 1'b0;
    logic reset;

    card_dealer_if bus ();

    card_dealer #(
        .DECK_SIZE(52),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_deck [52];
    int exp_cycles;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Expected deck order and reset-release-to-ready cycle count.
    task automatic build_model();
        logic [15:0] lfsr;
        int          i, j, t, steps;
        for (int k = 0; k < 52; k++) exp_deck[k] = k;
        lfsr  = lfsr_next(16'hACE1); // one shift during the fill cycle
        i     = 51;
        steps = 0;
        while (i > 0) begin
            j = int'(lfsr[5:0]);
            if (j <= i) begin
                t           = exp_deck[i];
                exp_deck[i] = exp_deck[j];
                exp_deck[j] = t;
                i--;
            end
            lfsr = lfsr_next(lfsr);
            steps++;
        end
        exp_cycles = steps + 1;
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_valid"}, int'(bus.card_valid), 0);
        check_eq({pfx, "_value"}, int'(bus.card_value), 0);
        check_eq({pfx, "_suit"},  int'(bus.card_suit),  0);
        check_eq({pfx, "_ready"}, int'(bus.deck_ready), 0);
        check_eq({pfx, "_left"},  int'(bus.cards_left), 0);
        check_eq({pfx, "_err"},   int'(bus.deal_err),   0);
    endtask

    task automatic wait_ready(input bit pulse, output int n);
        n = 0;
        while (1) begin
            @(posedge clock);
            #1;
            n++;
            if (pulse && n == 3) bus.deal_req = 1'b1;
            if (pulse && n == 4) begin
                bus.deal_req = 1'b0;
                check_eq("shuf_req_valid", int'(bus.card_valid), 0);
                check_eq("shuf_req_err", int'(bus.deal_err), 0);
            end
            if (bus.deck_ready) break;
            if (n >= 4000) begin
                check_eq("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic deal_all();
        int seen [52];
        int idx, distinct;
        for (int k = 0; k < 52; k++) seen[k] = 0;
        bus.deal_req = 1'b1;
        for (int k = 0; k < 52; k++) begin
            @(posedge clock);
            #1;
            if (k == 51) bus.deal_req = 1'b0;
            check_eq("deal_valid", int'(bus.card_valid), 1);
            check_eq("deal_value", int'(bus.card_value), exp_deck[k] % 13 + 1);
            check_eq("deal_suit", int'(bus.card_suit), exp_deck[k] / 13);
            check_eq("deal_left", int'(bus.cards_left), 51 - k);
            if (bus.card_value >= 4'd1 && bus.card_value <= 4'd13) begin
                idx = int'(bus.card_value) - 1 + 13 * int'(bus.card_suit);
                seen[idx]++;
            end
        end
        distinct = 0;
        for (int k = 0; k < 52; k++) if (seen[k] == 1) distinct++;
        check_eq("perm_distinct", distinct, 52);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset             = 1'b1;
        bus.deal_req      = 1'b0;
        bus.shuffle_start = 1'b0;
        build_model();

        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");

        // Fresh shuffle from seed: cycle count and order match the model.
        @(negedge clock) reset = 1'b0;
        wait_ready(1'b0, n);
        check_eq("shuffle_cycles", n, exp_cycles);
        check_eq("ready_left", int'(bus.cards_left), 52);
        deal_all();

        @(posedge clock);
        #1;
        check_eq("empty_left", int'(bus.cards_left), 0);
        check_eq("empty_ready", int'(bus.deck_ready), 1);
        check_eq("empty_valid", int'(bus.card_valid), 0);

        bus.deal_req = 1'b1;
        @(posedge clock);
        #1;
        bus.deal_req = 1'b0;
        check_eq("err_pulse", int'(bus.deal_err), 1);
        check_eq("err_valid", int'(bus.card_valid), 0);
        check_eq("err_left", int'(bus.cards_left), 0);
        check_eq("err_hold_value", int'(bus.card_value), exp_deck[51] % 13 + 1);
        check_eq("err_hold_suit", int'(bus.card_suit), exp_deck[51] / 13);
        @(posedge clock);
        #1;
        check_eq("err_clear", int'(bus.deal_err), 0);

        // Reshuffle from empty.
        bus.shuffle_start = 1'b1;
        @(posedge clock);
        #1;
        bus.shuffle_start = 1'b0;
        check_eq("restart_ready", int'(bus.deck_ready), 0);
        wait_ready(1'b0, n);
        check_eq("reshuf_left", int'(bus.cards_left), 52);

        // Ten deals, then shuffle_start wins over deal_req.
        bus.deal_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            check_eq("part_valid", int'(bus.card_valid), 1);
            check_eq("part_left", int'(bus.cards_left), 51 - k);
        end
        bus.shuffle_start = 1'b1;
        @(posedge clock);
        #1;
        bus.shuffle_start = 1'b0;
        bus.deal_req      = 1'b0;
        check_eq("prio_valid", int'(bus.card_valid), 0);
        check_eq("prio_ready", int'(bus.deck_ready), 0);
        check_eq("prio_left", int'(bus.cards_left), 0);

        // Asynchronous reset in the middle of the shuffle.
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // Same seed again, with a stray request during the shuffle.
        wait_ready(1'b1, n);
        check_eq("reseed_cycles", n, exp_cycles);
        check_eq("reseed_left", int'(bus.cards_left), 52);
        deal_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
